// File: rtl/asteroid_field.sv
// Asteroid lanes for a falling-block shooter: per-lane fall/explode FSMs,
// BCD score/health bookkeeping and registered pixel hit-tests for the video path.
module asteroid_field #(
    parameter int unsigned NUM_LANES    = 5,
    parameter int unsigned LANE_X0      = 208,
    parameter int unsigned LANE_PITCH   = 128,
    parameter int unsigned SQ_SIZE      = 32,
    parameter int unsigned STEP         = 4,
    parameter int unsigned PLANET_TOP   = 448,
    parameter int unsigned SPAWN_DELAY  = 8,
    parameter int unsigned ANIM_FRAMES  = 30,
    parameter logic [7:0]  START_HEALTH = 8'h10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_frame_tick,
    input  logic [NUM_LANES-1:0] i_fire,
    input  logic [9:0]           i_h_count,
    input  logic [9:0]           i_v_count,
    output logic                 o_draw_asteroid,
    output logic                 o_draw_explode,
    output logic [7:0]           o_score_bcd,
    output logic [7:0]           o_health_bcd,
    output logic                 o_game_over,
    output logic [NUM_LANES-1:0] o_lane_active
);

    typedef enum logic [1:0] {StIdle, StFall, StExplode} lane_state_e;

    lane_state_e          r_state [NUM_LANES];
    lane_state_e          w_state_next [NUM_LANES];
    logic [9:0]           r_y [NUM_LANES];
    logic [9:0]           w_y_next [NUM_LANES];
    logic [15:0]          r_delay [NUM_LANES];
    logic [15:0]          w_delay_next [NUM_LANES];
    logic [15:0]          r_anim [NUM_LANES];
    logic [15:0]          w_anim_next [NUM_LANES];
    logic [NUM_LANES-1:0] r_fire;
    logic [NUM_LANES-1:0] w_fire_edge;
    logic [NUM_LANES-1:0] w_kill;
    logic [NUM_LANES-1:0] w_hit;
    logic [NUM_LANES-1:0] w_in_box;
    logic [3:0]           w_kill_cnt;
    logic [3:0]           w_hit_cnt;
    logic [7:0]           r_score;
    logic [7:0]           r_health;
    logic [7:0]           w_score_next;
    logic [7:0]           w_health_next;
    int unsigned          w_score_sum;
    int unsigned          w_health_bin;
    logic                 r_game_over;
    logic                 w_game_over_next;
    logic                 r_draw_asteroid;
    logic                 r_draw_explode;
    logic                 w_box_asteroid;
    logic                 w_box_explode;

    function automatic logic [15:0] lane_reload(int unsigned lane);
        return 16'(SPAWN_DELAY + 4 * lane);
    endfunction

    function automatic int unsigned bcd2bin(logic [7:0] b);
        return 10 * 32'(b[7:4]) + 32'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Lane FSMs; a fire edge is checked before the frame tick so a kill beats a hit.
    always_comb begin
        w_fire_edge = i_fire & ~r_fire;
        w_kill      = '0;
        w_hit       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_state_next[i] = r_state[i];
            w_y_next[i]     = r_y[i];
            w_delay_next[i] = r_delay[i];
            w_anim_next[i]  = r_anim[i];
            if (!r_game_over) begin
                case (r_state[i])
                    StIdle: begin
                        if (i_frame_tick) begin
                            if (r_delay[i] == 16'd0) begin
                                w_state_next[i] = StFall;
                                w_y_next[i]     = 10'd0;
                            end else begin
                                w_delay_next[i] = r_delay[i] - 16'd1;
                            end
                        end
                    end
                    StFall: begin
                        if (w_fire_edge[i]) begin
                            w_state_next[i] = StExplode;
                            w_kill[i]       = 1'b1;
                            w_anim_next[i]  = 16'(ANIM_FRAMES - 1);
                        end else if (i_frame_tick) begin
                            if (({2'b00, r_y[i]} + 12'(STEP + SQ_SIZE)) >= 12'(PLANET_TOP)) begin
                                w_state_next[i] = StIdle;
                                w_hit[i]        = 1'b1;
                                w_delay_next[i] = lane_reload(i);
                            end else begin
                                w_y_next[i] = r_y[i] + 10'(STEP);
                            end
                        end
                    end
                    StExplode: begin
                        if (i_frame_tick) begin
                            if (r_anim[i] == 16'd0) begin
                                w_state_next[i] = StIdle;
                                w_delay_next[i] = lane_reload(i);
                            end else begin
                                w_anim_next[i] = r_anim[i] - 16'd1;
                            end
                        end
                    end
                    default: w_state_next[i] = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        w_kill_cnt = '0;
        w_hit_cnt  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_kill_cnt = w_kill_cnt + 4'(w_kill[i]);
            w_hit_cnt  = w_hit_cnt + 4'(w_hit[i]);
        end
        w_score_sum      = bcd2bin(r_score) + 32'(w_kill_cnt);
        w_score_next     = bin2bcd((w_score_sum > 99) ? 99 : w_score_sum);
        w_health_bin     = bcd2bin(r_health);
        w_health_next    = (32'(w_hit_cnt) >= w_health_bin) ? 8'h00
                                                            : bin2bcd(w_health_bin - 32'(w_hit_cnt));
        w_game_over_next = r_game_over | (w_health_next == 8'h00);
    end

    always_comb begin
        w_in_box       = '0;
        w_box_asteroid = 1'b0;
        w_box_explode  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_in_box[i] = ({2'b00, i_h_count} >= 12'(LANE_X0 + i * LANE_PITCH))
                       && ({2'b00, i_h_count} < 12'(LANE_X0 + i * LANE_PITCH + SQ_SIZE))
                       && ({2'b00, i_v_count} >= {2'b00, r_y[i]})
                       && ({2'b00, i_v_count} < ({2'b00, r_y[i]} + 12'(SQ_SIZE)));
            if (w_in_box[i] && r_state[i] == StFall)    w_box_asteroid = 1'b1;
            if (w_in_box[i] && r_state[i] == StExplode) w_box_explode  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_state[i] <= StIdle;
                r_y[i]     <= 10'd0;
                r_delay[i] <= lane_reload(i);
                r_anim[i]  <= 16'd0;
            end
            r_fire          <= '0;
            r_score         <= 8'h00;
            r_health        <= START_HEALTH;
            r_game_over     <= 1'b0;
            r_draw_asteroid <= 1'b0;
            r_draw_explode  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_state[i] <= w_game_over_next ? StIdle : w_state_next[i];
                r_y[i]     <= w_y_next[i];
                r_delay[i] <= w_delay_next[i];
                r_anim[i]  <= w_anim_next[i];
            end
            r_fire          <= i_fire;
            r_score         <= w_score_next;
            r_health        <= w_health_next;
            r_game_over     <= w_game_over_next;
            r_draw_asteroid <= w_box_asteroid & ~w_game_over_next;
            r_draw_explode  <= w_box_explode & ~w_game_over_next;
        end
    end

    always_comb begin
        o_lane_active = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            o_lane_active[i] = (r_state[i] == StFall);
        end
    end

    assign o_draw_asteroid = r_draw_asteroid;
    assign o_draw_explode  = r_draw_explode;
    assign o_score_bcd     = r_score;
    assign o_health_bcd    = r_health;
    assign o_game_over     = r_game_over;

endmodule
